// File: rtl/puf_pkg.sv
// Shared types and default widths for the PUF response sequencer.
package puf_pkg;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_SEL_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_SETTLE,
        ST_SAMP1,
        ST_SAMP2,
        ST_NEXT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/puf_window_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module puf_window_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    // Load on request, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/puf_response_sequencer.sv
// Sweeps the oscillator pairs, times clear/run/settle windows and builds
// one response bit per challenge from the two bank counts.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start; outputs hold the last result
// CLEAR    | cnt_clr high, sel = idx, CLR_CYCLES long
// RUN      | ro_en high, WIN_CYCLES long
// SETTLE   | oscillators stopped, counts settling, SETTLE_CYCLES long
// SAMP1    | capture both counts
// SAMP2    | re-read counts, flag instability, write response/tie bit
// NEXT     | advance idx or finish
// DONE     | resp_valid pulse
module puf_response_sequencer
    import puf_pkg::*;
#(
    parameter int NUM_CH        = 7,
    parameter int SEL_W         = DEF_SEL_W,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int CLR_CYCLES    = 2,
    parameter int WIN_CYCLES    = 64,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  count_a,
    input  logic [CNT_W-1:0]  count_b,
    output logic              ro_en,
    output logic              cnt_clr,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic [NUM_CH-1:0] response,
    output logic [NUM_CH-1:0] tie_mask,
    output logic              unstable,
    output logic              resp_valid
);

    // Timer holds duration-1, so it only needs to represent the longest window minus one.
    localparam int MAX_T = (WIN_CYCLES > CLR_CYCLES)
                         ? ((WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES)
                         : ((CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES);
    localparam int TMR_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    state_t             state;
    state_t             state_nxt;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_done;
    logic [SEL_W-1:0]   idx;
    logic [CNT_W-1:0]   cap_a;
    logic [CNT_W-1:0]   cap_b;
    logic               last_ch;

    assign last_ch = (idx == SEL_W'(NUM_CH - 1));

    puf_window_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; the timer is loaded on entry to each timed state.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_CLEAR;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(CLR_CYCLES - 1);
                end
            end
            ST_CLEAR: begin
                if (tmr_done) begin
                    state_nxt = ST_RUN;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(WIN_CYCLES - 1);
                end
            end
            ST_RUN: begin
                if (tmr_done) begin
                    state_nxt = ST_SETTLE;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(SETTLE_CYCLES - 1);
                end
            end
            ST_SETTLE: begin
                if (tmr_done) begin
                    state_nxt = ST_SAMP1;
                end
            end
            ST_SAMP1: state_nxt = ST_SAMP2;
            ST_SAMP2: state_nxt = ST_NEXT;
            ST_NEXT: begin
                if (last_ch) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_CLEAR;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(CLR_CYCLES - 1);
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Challenge index, sample capture and response assembly.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            idx      <= '0;
            cap_a    <= '0;
            cap_b    <= '0;
            response <= '0;
            tie_mask <= '0;
            unstable <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx      <= '0;
                        response <= '0;
                        tie_mask <= '0;
                        unstable <= 1'b0;
                    end
                end
                ST_SAMP1: begin
                    cap_a <= count_a;
                    cap_b <= count_b;
                end
                ST_SAMP2: begin
                    if ((count_a != cap_a) || (count_b != cap_b)) begin
                        unstable <= 1'b1;
                    end
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (idx == SEL_W'(i)) begin
                            response[i] <= (count_a > count_b);
                            tie_mask[i] <= (count_a == count_b);
                        end
                    end
                end
                ST_NEXT: begin
                    if (!last_ch) begin
                        idx <= idx + SEL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ro_en      = (state == ST_RUN);
    assign cnt_clr    = (state == ST_CLEAR);
    assign busy       = (state != ST_IDLE) && (state != ST_DONE);
    assign resp_valid = (state == ST_DONE);
    assign sel        = idx;

endmodule
